// File: rtl/pll_lock_sequencer.sv
// PLL power-up / lock-loss sequencer for the iCE40 SB_PLL40_CORE, clocked from the reference clock.
// Holds the PLL in reset, waits for a stable lock with timeout and retry budget, then releases the core.
module pll_lock_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES    = 3,
  parameter int BYPASS_ON_FAIL = 1,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retries,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       L_MAX_RETRIES = 4'(MAX_RETRIES);
  localparam logic             L_BYPASS      = (BYPASS_ON_FAIL != 0);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [3:0]       r_retries;
  logic [3:0]       w_next_retries;
  logic             w_lock_lost;
  logic             r_sync1;
  logic             r_lock_s;
  logic             r_pll_resetb;
  logic             r_pll_bypass;
  logic             r_sys_reset_n;
  logic             r_ready;
  logic             r_fail;
  logic             r_lock_lost;

  // LOCK comes from the PLL analog block, so it is asynchronous to the reference clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= locked;
      r_lock_s <= r_sync1;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_next_retries = r_retries;
    w_lock_lost    = 1'b0;
    if (restart) begin
      w_next_state   = S_RESET;
      w_next_cnt     = '0;
      w_next_retries = '0;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_cnt == L_RST_LAST) begin
            w_next_state = S_WAIT;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (r_lock_s) begin
            w_next_state = S_STABLE;
            w_next_cnt   = '0;
          end else if (r_cnt == L_TIMEOUT_LAST) begin
            w_next_cnt = '0;
            if (r_retries == L_MAX_RETRIES) begin
              w_next_state = S_FAIL;
            end else begin
              w_next_state = S_RESET;
              if (r_retries != 4'd15) w_next_retries = r_retries + 4'd1;
            end
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
        S_STABLE: begin
          // A dropout restarts the lock timeout but is not charged as a retry.
          if (!r_lock_s) begin
            w_next_state = S_WAIT;
            w_next_cnt   = '0;
          end else if (r_cnt == L_STABLE_LAST) begin
            w_next_state   = S_RUN;
            w_next_cnt     = '0;
            w_next_retries = '0;
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          w_next_cnt = '0;
          if (!r_lock_s) begin
            w_next_state = S_RESET;
            w_lock_lost  = 1'b1;
          end
        end
        S_FAIL: begin
          w_next_cnt = '0;
        end
        default: begin
          w_next_state = S_RESET;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RESET;
      r_cnt         <= '0;
      r_retries     <= '0;
      r_pll_resetb  <= 1'b0;
      r_pll_bypass  <= 1'b0;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_fail        <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_retries     <= w_next_retries;
      r_pll_resetb  <= (w_next_state != S_RESET);
      r_pll_bypass  <= (w_next_state == S_FAIL) && L_BYPASS;
      r_sys_reset_n <= (w_next_state == S_RUN) || ((w_next_state == S_FAIL) && L_BYPASS);
      r_ready       <= (w_next_state == S_RUN);
      r_fail        <= (w_next_state == S_FAIL);
      r_lock_lost   <= w_lock_lost;
    end
  end

  assign pll_resetb  = r_pll_resetb;
  assign pll_bypass  = r_pll_bypass;
  assign sys_reset_n = r_sys_reset_n;
  assign ready       = r_ready;
  assign fail        = r_fail;
  assign lock_lost   = r_lock_lost;
  assign retries     = r_retries;
  assign dbg_state   = r_state;

endmodule
